// File: rtl/mat_mac_pkg.sv
// mat_mac_pkg: shared constants and types for the 3x3 matrix-MAC host interface.
//   DW_DEF / RW_DEF : default operand / result element widths
//   N_ELEM / N_IN   : elements per matrix / operand bytes per transaction
//   IDX_W / RIDX_W  : widths of the operand-load and result-stream indices
//   state_e         : host FSM state encoding
package mat_mac_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned RW_DEF = 16;
  localparam int unsigned N_ELEM = 9;
  localparam int unsigned N_IN   = 18;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned RIDX_W = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    SEND = 2'd3
  } state_e;

endpackage

// File: rtl/mat_result_streamer.sv
// mat_result_streamer: captures the nine core results on a load strobe and streams them
// out c11..c33 over a valid/ready interface.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture mat_c and start streaming
//   mat_c           : 9*RW results, c11 in the low word
//   out_ready       : downstream accepts
//   out_valid/out_data/out_last : result stream, out_last with c33
//   last_accepted   : c33 is being accepted this cycle
module mat_result_streamer
  import mat_mac_pkg::*;
#(
  parameter int unsigned RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [9*RW-1:0]      mat_c,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [RW-1:0]        out_data,
  output logic                 out_last,
  output logic                 last_accepted
);

  logic [RW-1:0]     r_res [N_ELEM];
  logic [RIDX_W-1:0] r_ridx;
  logic              r_valid;
  logic              w_at_last;

  assign w_at_last = (r_ridx == RIDX_W'(N_ELEM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < N_ELEM; e++) r_res[e] <= '0;
      r_ridx  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      for (int e = 0; e < N_ELEM; e++) r_res[e] <= mat_c[e*RW +: RW];
      r_ridx  <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      if (w_at_last) begin
        r_ridx  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ridx <= r_ridx + RIDX_W'(1);
      end
    end
  end

  // Explicit mux keeps the 4-bit index from reaching past the nine entries.
  always_comb begin
    out_data = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      if (r_ridx == RIDX_W'(e)) out_data = r_res[e];
    end
  end

  assign out_valid     = r_valid;
  assign out_last      = r_valid && w_at_last;
  assign last_accepted = r_valid && out_ready && w_at_last;

endmodule

// File: rtl/mat_mac_host_if.sv
// mat_mac_host_if: host-side initiator for the 3x3 matrix multiply core. Assembles A and B
// from an operand byte stream, runs the core with a watchdog, then streams the results.
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready   : operand bytes a11..a33 then b11..b33
//   out_valid/out_data/out_last/out_ready : results c11..c33
//   mat_a, mat_b, start         : to core (element 0 in the low bits)
//   mat_c, done                 : from core
//   busy                        : any state but LOAD
//   err                         : sticky watchdog timeout flag
module mat_mac_host_if
  import mat_mac_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [RW-1:0]     out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [9*DW-1:0]   mat_a,
  output logic [9*DW-1:0]   mat_b,
  output logic              start,
  input  logic [9*RW-1:0]   mat_c,
  input  logic              done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e            r_state, w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic [9*DW-1:0]   r_mat_a, r_mat_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              w_in_acc, w_capture, w_expire, w_last_acc;

  assign w_in_acc  = in_valid && (r_state == LOAD);
  assign w_capture = (r_state == RUN) && done;
  // done in the expiry cycle wins, so expiry requires done low.
  assign w_expire  = (r_state == RUN) && !done && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      LOAD: if (w_in_acc && (r_idx == IDX_W'(N_IN - 1))) w_state_next = ARM;
      // A done left high from the previous op must drop before we start.
      ARM:  if (!done) w_state_next = RUN;
      RUN: begin
        if (done)          w_state_next = SEND;
        else if (w_expire) w_state_next = LOAD;
      end
      SEND: if (w_last_acc) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
      r_idx   <= '0;
      r_mat_a <= '0;
      r_mat_b <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_in_acc) begin
        r_idx <= (r_idx == IDX_W'(N_IN - 1)) ? '0 : r_idx + IDX_W'(1);
        for (int e = 0; e < N_ELEM; e++) begin
          if (r_idx == IDX_W'(e))          r_mat_a[e*DW +: DW] <= in_data;
          if (r_idx == IDX_W'(e + N_ELEM)) r_mat_b[e*DW +: DW] <= in_data;
        end
      end
      if (r_state == ARM) begin
        r_cnt <= '0;
      end else if ((r_state == RUN) && !done && !w_expire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_expire) r_err <= 1'b1;
    end
  end

  mat_result_streamer #(
    .RW (RW)
  ) u_streamer (
    .clk           (clk),
    .rst           (rst),
    .load          (w_capture),
    .mat_c         (mat_c),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .last_accepted (w_last_acc)
  );

  assign in_ready = (r_state == LOAD);
  assign start    = (r_state == RUN);
  assign busy     = (r_state != LOAD);
  assign err      = r_err;
  assign mat_a    = r_mat_a;
  assign mat_b    = r_mat_b;

endmodule

// File: tb/tb_mat_mac_host_if.sv
module tb_mat_mac_host_if;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              out_valid;
  logic [RW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [9*DW-1:0]   mat_a, mat_b;
  logic              start;
  logic [9*RW-1:0]   mat_c;
  logic              done;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  mat_mac_host_if #(
    .DW      (DW),
    .RW      (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .start     (start),
    .mat_c     (mat_c),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [RW-1:0] sb [$];
  logic [DW-1:0] ops [18];
  logic [9*DW-1:0] exp_a, exp_b;
  int            core_mode;   // 0: done after 6 start cycles, 1: never done
  bit            hold_done;
  int            core_cnt;
  bit            pat6 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [9*RW-1:0] matmul(logic [9*DW-1:0] a, logic [9*DW-1:0] b);
    logic [9*RW-1:0] r;
    logic [31:0]     acc;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        for (int k = 0; k < 3; k++)
          acc += 32'(a[(3*i+k)*DW +: DW]) * 32'(b[(3*k+j)*DW +: DW]);
        r[(3*i+j)*RW +: RW] = acc[RW-1:0];
      end
    end
    return r;
  endfunction

  // Core model, driven away from the active edge.
  always @(negedge clk) begin
    if (rst || !start) begin
      core_cnt = 0;
      if (!hold_done) done = 1'b0;
    end else begin
      core_cnt++;
      if (core_mode == 0 && core_cnt == 6) begin
        mat_c = matmul(mat_a, mat_b);
        done  = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ops(input bit gaps, input bit push);
    logic [31:0] acc;
    for (int e = 0; e < 9; e++) begin
      exp_a[e*DW +: DW] = ops[e];
      exp_b[e*DW +: DW] = ops[9+e];
    end
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          acc = 0;
          for (int k = 0; k < 3; k++) acc += 32'(ops[3*i+k]) * 32'(ops[9+3*k+j]);
          sb.push_back(acc[RW-1:0]);
        end
      end
    end
    for (int i = 0; i < 18; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      chk("in_ready_load", 128'(in_ready), 128'(1));
      tick();
    end
    in_valid = 1'b0;
    chk("arm_start_low", 128'(start), 128'(0));
    chk("arm_busy", 128'(busy), 128'(1));
    chk("mat_a_pack", 128'(mat_a), 128'(exp_a));
    chk("mat_b_pack", 128'(mat_b), 128'(exp_b));
  endtask

  // Runs from ARM until nwords results are accepted; pat 1 applies backpressure.
  task automatic run_txn(input int pat, input int nwords, input bit offer);
    int st_cnt = 0;
    int got = 0;
    int cyc = 0;
    int vidx = 0;
    bit hold_v = 1'b0;
    logic [RW-1:0] hd = '0;
    logic hl = 1'b0;
    logic [RW-1:0] e;
    in_valid = offer;
    in_data  = 8'hEE;
    while (got < nwords && cyc < 300) begin
      if (start) st_cnt++;
      chk("in_ready_busy", 128'(in_ready), 128'(0));
      if (hold_v) begin
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_data", 128'(out_data), 128'(hd));
        chk("stall_last", 128'(out_last), 128'(hl));
      end
      if (out_valid) begin
        out_ready = (pat == 0) ? 1'b1 : pat6[vidx % 6];
        vidx++;
        if (out_ready) begin
          e = (sb.size() > 0) ? sb.pop_front() : 'x;
          chk("out_data", 128'(out_data), 128'(e));
          chk("out_last", 128'(out_last), 128'(got == 8));
          got++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hd = out_data;
          hl = out_last;
        end
      end else begin
        out_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("words_accepted", 128'(got), 128'(nwords));
    if (nwords == 9) begin
      chk("start_cycles", 128'(st_cnt), 128'(6));
      chk("end_out_valid", 128'(out_valid), 128'(0));
      chk("end_busy", 128'(busy), 128'(0));
      chk("end_in_ready", 128'(in_ready), 128'(1));
      chk("end_mat_a", 128'(mat_a), 128'(exp_a));
    end
  endtask

  initial begin
    int sc;
    hold_done = 1'b0;
    core_mode = 0;
    done      = 1'b0;
    mat_c     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_start", 128'(start), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_mat_a", 128'(mat_a), 128'(0));
    rst = 1'b0;
    tick();

    // Basic op: A=1..9, B=9..1 -> 30,24,18,84,69,54,138,114,90
    for (int i = 0; i < 9; i++) begin
      ops[i]   = DW'(i + 1);
      ops[9+i] = DW'(9 - i);
    end
    load_ops(1'b0, 1'b1);
    run_txn(0, 9, 1'b0);
    chk("basic_err", 128'(err), 128'(0));

    // Backpressure with random operands
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b0, 1'b1);
    run_txn(1, 9, 1'b0);

    // Input gaps and extra bytes offered while busy
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b1, 1'b1);
    run_txn(0, 9, 1'b1);

    // Watchdog: core never answers
    core_mode = 1;
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b0, 1'b0);
    sc = 0;
    for (int c = 0; c < 100; c++) begin
      if (start) sc++;
      else if (sc > 0) break;
      tick();
    end
    chk("wd_start_cycles", 128'(sc), 128'(TO));
    chk("wd_err", 128'(err), 128'(1));
    chk("wd_in_ready", 128'(in_ready), 128'(1));
    chk("wd_busy", 128'(busy), 128'(0));
    chk("wd_out_valid", 128'(out_valid), 128'(0));
    core_mode = 0;
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b0, 1'b1);
    run_txn(0, 9, 1'b0);
    chk("wd_err_sticky", 128'(err), 128'(1));

    // Stale done held high on entry to ARM
    hold_done = 1'b1;
    done      = 1'b1;
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("stale_start_low", 128'(start), 128'(0));
      chk("stale_busy", 128'(busy), 128'(1));
      tick();
    end
    hold_done = 1'b0;
    done      = 1'b0;
    run_txn(0, 9, 1'b0);

    // Reset in the middle of SEND
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b0, 1'b1);
    run_txn(0, 4, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out_data", 128'(out_data), 128'(0));
    chk("mid_rst_out_last", 128'(out_last), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_err", 128'(err), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_mat_b", 128'(mat_b), 128'(0));
    tick();
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("post_rst_no_output", 128'(out_valid), 128'(0));
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) ops[i] = DW'($urandom);
    load_ops(1'b0, 1'b1);
    run_txn(1, 9, 1'b0);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mat_mac_host_if.md
# mat_mac_host_if

Host-side initiator for the 3x3 matrix multiply core (`matrix_pipeline_mac_top`). It does three things in order:
- Accepts a byte stream of operands and assembles matrices A and B.
- Drives them and `start` to the core, then waits for `done`, with a watchdog.
- Captures the nine results and streams them out over a valid/ready interface.

It sits between the system stream fabric and the core, replacing the hand-driven parallel stimulus with a real transaction engine.

## Interface
- DW, 8, operand element width
- RW, 16, result element width
- TIMEOUT, 255, maximum cycles in RUN without `done` before abort (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand byte valid
- in_data  in  DW  operand byte; order a11..a33 row-major, then b11..b33
- in_ready  out  1  operand byte accepted when in_valid&&in_ready
- out_valid  out  1  result word valid
- out_data  out  RW  result word; order c11..c33 row-major
- out_last  out  1  high with c33
- out_ready  in  1  downstream accepts
- mat_a  out  9*DW  to core; a11 at [DW-1:0] … a33 at top
- mat_b  out  9*DW  to core; same packing
- start  out  1  to core
- mat_c  in  9*RW  from core; c11 at [RW-1:0] … c33 at top
- done  in  1  from core
- busy  out  1  high in any state but LOAD
- err  out  1  sticky timeout flag; cleared only by rst

## Operation
- **States:** LOAD, ARM, RUN, SEND.
- **LOAD:**
  - in_ready=1.
  - A 5-bit index counts 0..17; each accepted byte is written to element[index] (0..8 → A, 9..17 → B).
  - The accept of index 17 moves to ARM and clears the index.
- **ARM:**
  - start=0.
  - Stays here while done=1, so a stale `done` from the previous op is not taken as completion.
  - done=0 → RUN; the watchdog counter clears to 0.
- **RUN:**
  - start=1 for as long as the state is RUN.
  - done=1 → capture all nine mat_c words into result registers on that edge, then go to SEND.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with done=0: set err=1, discard the operation, go to LOAD.
  - done and expiry in the same cycle → done wins.
- **SEND:**
  - out_valid=1; out_data=result[ridx]; out_last=(ridx==8).
  - ridx advances only on out_valid&&out_ready.
  - The accept with ridx==8 → LOAD, ridx cleared.
- **Ports that are not driven in a state:**
  - in_valid outside LOAD is ignored; in_ready=0.
  - out_ready outside SEND is ignored.
- **Register persistence:** mat_a/mat_b hold their last written values across states. They are overwritten element by element during the next LOAD.
- **Arithmetic:** none. Result words pass through at RW bits unchanged; any overflow truncation happens in the core.

## Timing
- **Reset values:** state=LOAD, indices and counter 0, mat_a=mat_b=0, results=0, start=0, in_ready=1 (LOAD decode), out_valid=0, out_last=0, out_data=0, busy=0, err=0.
- **Output decode:** in_ready, start, out_valid, out_last and busy are decodes of registered state/index only. None has a combinational path from any input.
- **Load latency:** 18th byte accepted at edge k → ARM during cycle k. With done=0 → start high from edge k+1.
- **Capture latency:** done sampled high at edge m → start low and out_valid high from edge m. out_data=c11 from edge m.
- **Throughput:** one result per cycle with out_ready tied high. Minimum transaction is 18 + 1 + RUN + 9 cycles.
- **Stall:** out_data and out_last hold stable while out_valid&&!out_ready.
- **Timeout:** start is high exactly TIMEOUT cycles, then err rises and in_ready returns on the same edge.
- **Reset mid-operation:** every register returns to its reset value immediately, partial operands and results are lost, and no stale word is emitted afterwards.

## Structure
- **Package `mat_mac_pkg`:**
  - DW, RW defaults.
  - N_ELEM=9, N_IN=18.
  - state encoding constants LOAD/ARM/RUN/SEND.
  - Index width constants.
- **Sub-module `mat_result_streamer`:**
  - Holds the 9×RW capture registers, ridx, out_valid/out_data/out_last.
  - Has a `load` strobe input and a `last_accepted` output.
- **Top:** the FSM, operand registers and watchdog live here.

## Test plan
- **Basic op:** A=1..9, B=9..8..1, core model gives done 6 cycles after start → stream 30,24,18,84,69,54,138,114,90; out_last only with 90; err=0.
- **Backpressure:** out_ready pattern 1,0,0,1,0,1… → same 9 words in order, data and out_last stable during stalls, no duplicates or drops.
- **Input gaps:** random in_valid gaps → identical mat_a/mat_b packing; in_ready=0 throughout ARM/RUN/SEND; extra bytes offered then are not consumed.
- **Watchdog:** TIMEOUT=16, core never asserts done → start high exactly 16 cycles, err=1 thereafter, state LOAD. A following good transaction completes with err still 1.
- **Stale done:** done held high when ARM is entered → start stays 0 until done drops, then the transaction completes normally.
- **Reset mid-op:**
  - rst pulse during SEND after 4 words → all outputs at reset values, no further output.
  - A new 18-byte load produces the correct full 9-word stream.
